// File: rtl/exc_intr_unit_pkg.sv
// Shared constants for the exception/interrupt unit: exception codes,
// CP0 register addresses, Status/Cause bit positions and the event type.
package exc_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [1:0] C0_STATUS = 2'd0;
  localparam logic [1:0] C0_CAUSE  = 2'd1;
  localparam logic [1:0] C0_EPC    = 2'd2;
  localparam logic [1:0] C0_RSVD   = 2'd3;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_IM  = 8;
  localparam int CA_EXC = 2;
  localparam int CA_IP  = 8;

  typedef enum logic [2:0] {
    EV_NONE = 3'd0,
    EV_OV   = 3'd1,
    EV_RI   = 3'd2,
    EV_ERET = 3'd3,
    EV_INT  = 3'd4
  } event_e;

  // Isolates the lowest set bit (two's-complement trick)
  function automatic logic [7:0] lowest_set(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

endpackage

// File: rtl/exc_intr_unit_if.sv
// Retire-stage / CP0-access bus between the datapath (master) and the
// exception/interrupt unit (slave).
interface exc_intr_unit_if;
  logic [31:0] Pc;
  logic        Pc_valid;
  logic        Ovf;
  logic        Ovf_en;
  logic        Illegal;
  logic        Eret;
  logic        C0_we;
  logic [1:0]  C0_addr;
  logic [31:0] C0_wdata;
  logic [31:0] C0_rdata;
  logic        Kill;
  logic        Redirect;
  logic [31:0] Redirect_pc;

  modport master (
    output Pc, Pc_valid, Ovf, Ovf_en, Illegal, Eret, C0_we, C0_addr, C0_wdata,
    input  C0_rdata, Kill, Redirect, Redirect_pc
  );

  modport slave (
    input  Pc, Pc_valid, Ovf, Ovf_en, Illegal, Eret, C0_we, C0_addr, C0_wdata,
    output C0_rdata, Kill, Redirect, Redirect_pc
  );
endinterface

// File: rtl/exc_intr_unit_irq_sync.sv
// Two-flop synchroniser for one asynchronous interrupt request line.
module irq_sync (
  input  logic Clk,
  input  logic Clrn,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Metastability filter chain
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/exc_intr_unit.sv
// Exception/interrupt controller: CP0 Status/Cause/EPC, event priority, fetch redirect
// and interrupt acknowledge. Define VECTORED_EN for per-ExcCode handler entry points.
module exc_intr_unit
  import exc_pkg::*;
#(
  parameter int          NUM_IRQ      = 4,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0008
) (
  input  logic               Clk,
  input  logic               Clrn,
  exc_intr_unit_if.slave     bus,
  input  logic [NUM_IRQ-1:0] Irq,
  output logic [NUM_IRQ-1:0] Irq_ack
);

  logic               r_ie;
  logic               r_exl;
  logic [NUM_IRQ-1:0] r_im;
  logic [4:0]         r_exc_code;
  logic [31:0]        r_epc;
  logic [NUM_IRQ-1:0] r_ack;

  logic [NUM_IRQ-1:0] w_ip;
  logic [NUM_IRQ-1:0] w_pend;
  logic [7:0]         w_low8;
  logic [NUM_IRQ-1:0] w_ack_oh;
  event_e             w_ev;
  logic [4:0]         w_code;
  logic [31:0]        w_handler;
  logic               w_c0_wr;
  logic [31:0]        w_status;
  logic [31:0]        w_cause;
  logic               w_unused;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync u_sync (
      .Clk     (Clk),
      .Clrn    (Clrn),
      .i_async (Irq[g]),
      .o_sync  (w_ip[g])
    );
  end

  assign w_pend   = w_ip & r_im;
  assign w_low8   = lowest_set(8'(w_pend));
  assign w_ack_oh = w_low8[NUM_IRQ-1:0];
  assign w_unused = ^bus.C0_wdata;

  // Event selection in priority order Ov > RI > ERET > Int
  always_comb begin
    w_ev = EV_NONE;
    if (!bus.Pc_valid) begin
      w_ev = EV_NONE;
    end else if (bus.Ovf && bus.Ovf_en) begin
      w_ev = EV_OV;
    end else if (bus.Illegal || (bus.Eret && !r_exl)) begin
      w_ev = EV_RI;
    end else if (bus.Eret) begin
      w_ev = EV_ERET;
    end else if (r_ie && !r_exl && (|w_pend)) begin
      w_ev = EV_INT;
    end else begin
      w_ev = EV_NONE;
    end
  end

  // Exception code and handler target for the event taken this cycle
  always_comb begin
    w_code = EXC_INT;
    case (w_ev)
      EV_OV:   w_code = EXC_OV;
      EV_RI:   w_code = EXC_RI;
      default: w_code = EXC_INT;
    endcase
`ifdef VECTORED_EN
    w_handler = HANDLER_ADDR + {25'd0, w_code, 2'b00};
`else
    w_handler = HANDLER_ADDR;
`endif
  end

  assign bus.Kill        = (w_ev == EV_OV) || (w_ev == EV_RI);
  assign bus.Redirect    = (w_ev != EV_NONE);
  assign bus.Redirect_pc = (w_ev == EV_ERET) ? r_epc : w_handler;
  assign w_c0_wr         = bus.C0_we && (w_ev != EV_OV) && (w_ev != EV_RI) && (w_ev != EV_INT);
  assign Irq_ack         = r_ack;

  // Architectural view of Status and Cause
  always_comb begin
    w_status                    = 32'd0;
    w_status[ST_IE]             = r_ie;
    w_status[ST_EXL]            = r_exl;
    w_status[ST_IM +: NUM_IRQ]  = r_im;
    w_cause                     = 32'd0;
    w_cause[CA_EXC +: 5]        = r_exc_code;
    w_cause[CA_IP +: NUM_IRQ]   = w_ip;
  end

  // MFC0 read mux
  always_comb begin
    bus.C0_rdata = 32'd0;
    case (bus.C0_addr)
      C0_STATUS: bus.C0_rdata = w_status;
      C0_CAUSE:  bus.C0_rdata = w_cause;
      C0_EPC:    bus.C0_rdata = r_epc;
      default:   bus.C0_rdata = 32'd0;
    endcase
  end

  // CP0 state update; a later MTC0 overrides the ERET EXL clear
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_ie       <= 1'b0;
      r_exl      <= 1'b0;
      r_im       <= '0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'd0;
      r_ack      <= '0;
    end else begin
      r_ack <= '0;
      case (w_ev)
        EV_OV, EV_RI: begin
          r_exc_code <= w_code;
          r_exl      <= 1'b1;
          if (!r_exl) begin
            r_epc <= bus.Pc;
          end
        end
        EV_INT: begin
          r_exc_code <= EXC_INT;
          r_exl      <= 1'b1;
          r_epc      <= bus.Pc + 32'd4;
          r_ack      <= w_ack_oh;
        end
        EV_ERET: r_exl <= 1'b0;
        default: ;
      endcase
      if (w_c0_wr) begin
        case (bus.C0_addr)
          C0_STATUS: begin
            r_ie  <= bus.C0_wdata[ST_IE];
            r_exl <= bus.C0_wdata[ST_EXL];
            r_im  <= bus.C0_wdata[ST_IM +: NUM_IRQ];
          end
          C0_EPC:  r_epc <= bus.C0_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exc_intr_unit.sv
// Scoreboard bench for exc_intr_unit: expectations queued at drive time, popped at sample time.
module tb_exc_intr_unit;
  import exc_pkg::*;

`ifdef VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic       Clk;
  logic       Clrn;
  logic [3:0] Irq;
  logic [3:0] Irq_ack;

  exc_intr_unit_if bus_if ();

  exc_intr_unit #(.NUM_IRQ(4), .HANDLER_ADDR(32'h0000_0008)) dut (
    .Clk     (Clk),
    .Clrn    (Clrn),
    .bus     (bus_if),
    .Irq     (Irq),
    .Irq_ack (Irq_ack)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [31:0] hv(input logic [4:0] c);
    return VEC ? (32'h0000_0008 + {25'd0, c, 2'b00}) : 32'h0000_0008;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, obs, e);
    end
  endtask

  task automatic retire(input logic [31:0] pc, input logic ovf, input logic oen,
                        input logic ill, input logic er, input logic ek,
                        input logic erd, input logic [31:0] erpc);
    bus_if.Pc       = pc;
    bus_if.Pc_valid = 1'b1;
    bus_if.Ovf      = ovf;
    bus_if.Ovf_en   = oen;
    bus_if.Illegal  = ill;
    bus_if.Eret     = er;
    sb_push("kill", 32'(ek));
    sb_push("redirect", 32'(erd));
    if (erd) sb_push("redirect_pc", erpc);
    #1;
    sb_pop(32'(bus_if.Kill));
    sb_pop(32'(bus_if.Redirect));
    if (erd) sb_pop(bus_if.Redirect_pc);
    @(negedge Clk);
    bus_if.Pc_valid = 1'b0;
    bus_if.Ovf      = 1'b0;
    bus_if.Ovf_en   = 1'b0;
    bus_if.Illegal  = 1'b0;
    bus_if.Eret     = 1'b0;
    bus_if.C0_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
    bus_if.C0_addr = a;
    sb_push(tag, exp);
    #1;
    sb_pop(bus_if.C0_rdata);
    @(negedge Clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.C0_we    = 1'b1;
    bus_if.C0_addr  = a;
    bus_if.C0_wdata = d;
    @(negedge Clk);
    bus_if.C0_we    = 1'b0;
  endtask

  task automatic ack_chk(input string tag, input logic [3:0] exp);
    sb_push(tag, 32'(exp));
    sb_pop(32'(Irq_ack));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    Clrn            = 1'b0;
    Irq             = 4'b0000;
    bus_if.Pc       = 32'd0;
    bus_if.Pc_valid = 1'b0;
    bus_if.Ovf      = 1'b0;
    bus_if.Ovf_en   = 1'b0;
    bus_if.Illegal  = 1'b0;
    bus_if.Eret     = 1'b0;
    bus_if.C0_we    = 1'b0;
    bus_if.C0_addr  = 2'd0;
    bus_if.C0_wdata = 32'd0;
    idle(2);
    // reset state
    rd(C0_STATUS, "rst_status", 32'h0);
    rd(C0_CAUSE,  "rst_cause",  32'h0);
    rd(C0_EPC,    "rst_epc",    32'h0);
    sb_push("rst_kill", 32'd0);
    sb_push("rst_redirect", 32'd0);
    sb_pop(32'(bus_if.Kill));
    sb_pop(32'(bus_if.Redirect));
    ack_chk("rst_ack", 4'b0000);
    Clrn = 1'b1;
    idle(1);

    // overflow trap
    retire(32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, hv(EXC_OV));
    rd(C0_EPC,    "ov_epc",    32'h40);
    rd(C0_CAUSE,  "ov_cause",  32'h30);
    rd(C0_STATUS, "ov_status", 32'h2);

    // untrapped overflow, then illegal opcode, then nested illegal keeps EPC
    wr(C0_STATUS, 32'h0);
    retire(32'h48, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rd(C0_CAUSE, "noev_cause", 32'h30);
    retire(32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, hv(EXC_RI));
    rd(C0_CAUSE,  "ri_cause",  32'h28);
    rd(C0_EPC,    "ri_epc",    32'h44);
    rd(C0_STATUS, "ri_status", 32'h2);
    retire(32'h50, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, hv(EXC_RI));
    rd(C0_EPC, "nested_epc", 32'h44);

    // interrupt on line 0
    wr(C0_STATUS, 32'h101);
    rd(C0_STATUS, "st_wr", 32'h101);
    Irq = 4'b0001;
    idle(3);
    rd(C0_CAUSE, "ip_cause", 32'h128);
    sb_push("idle_redirect", 32'd0);
    sb_pop(32'(bus_if.Redirect));
    retire(32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, hv(EXC_INT));
    ack_chk("int_ack", 4'b0001);
    idle(1);
    ack_chk("int_ack_drop", 4'b0000);
    rd(C0_EPC,    "int_epc",    32'h84);
    rd(C0_STATUS, "int_status", 32'h103);
    rd(C0_CAUSE,  "int_cause",  32'h100);

    // overflow inside handler with IRQ pending, then ERET
    retire(32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, hv(EXC_OV));
    ack_chk("exl_no_ack", 4'b0000);
    rd(C0_EPC,   "exl_epc",   32'h84);
    rd(C0_CAUSE, "exl_cause", 32'h130);
    Irq = 4'b0000;
    idle(3);
    retire(32'h14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h84);
    rd(C0_STATUS, "eret_status", 32'h101);

    // lowest qualifying line wins; EPC wraps
    wr(C0_STATUS, 32'hF01);
    Irq = 4'b1100;
    idle(3);
    retire(32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, hv(EXC_INT));
    ack_chk("low_ack", 4'b0100);
    rd(C0_EPC,    "wrap_epc",    32'h0);
    rd(C0_STATUS, "wrap_status", 32'hF03);
    rd(C0_CAUSE,  "wrap_cause",  32'hC00);
    wr(C0_STATUS, 32'h301);
    retire(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    Irq = 4'b0000;
    idle(3);

    // MTC0 dropped by a same-cycle overflow; ERET with EXL=0 is RI
    wr(C0_STATUS, 32'h0);
    bus_if.C0_we    = 1'b1;
    bus_if.C0_addr  = C0_STATUS;
    bus_if.C0_wdata = 32'h301;
    retire(32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, hv(EXC_OV));
    rd(C0_STATUS, "drop_status", 32'h2);
    rd(C0_EPC,    "drop_epc",    32'h300);
    wr(C0_STATUS, 32'h0);
    retire(32'h304, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, hv(EXC_RI));
    rd(C0_CAUSE, "eret_ri_cause", 32'h28);
    rd(C0_EPC,   "eret_ri_epc",   32'h304);
    wr(C0_EPC, 32'h1234);
    rd(C0_EPC, "mtc0_epc", 32'h1234);
    wr(C0_RSVD, 32'hFFFF);
    rd(C0_RSVD, "rsvd", 32'h0);
    wr(C0_CAUSE, 32'hFFFF_FFFF);
    rd(C0_CAUSE, "cause_ro", 32'h28);

    // reset in the middle of an interrupt handler
    wr(C0_STATUS, 32'h101);
    Irq = 4'b0001;
    idle(3);
    retire(32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, hv(EXC_INT));
    ack_chk("pre_rst_ack", 4'b0001);
    Clrn = 1'b0;
    #1;
    ack_chk("rst_ack_drop", 4'b0000);
    rd(C0_STATUS, "mid_rst_status", 32'h0);
    rd(C0_CAUSE,  "mid_rst_cause",  32'h0);
    rd(C0_EPC,    "mid_rst_epc",    32'h0);
    Clrn = 1'b1;
    Irq  = 4'b0000;
    idle(3);
    retire(32'h500, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, hv(EXC_OV));
    rd(C0_EPC, "post_rst_epc", 32'h500);

    check_val("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
